// File: rtl/clock_100_pkg.sv
// Shared constants and helpers for the clock_100 generator family.
package clock_100_pkg;

  localparam int HALF_PERIOD_DEF = 50;
  localparam int CNT_W_DEF       = 16;

  // Half-period counter width; a one-cycle half period still needs one bit.
  function automatic int hc_width(input int half_period);
    return (half_period <= 2) ? 1 : $clog2(half_period);
  endfunction

endpackage

// File: rtl/clock_100_en_sync.sv
// Two-flop synchronizer for the run enable of clock_100_gen.
module clock_100_en_sync
  import clock_100_pkg::*;
(
  input  logic Clk,
  input  logic Reset_n,
  input  logic En_Async,
  output logic En_Sync
);

  logic en_p0;
  logic en_p1;

  // Stage 0 -> stage 1: metastability settling
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      en_p0 <= 1'b0;
      en_p1 <= 1'b0;
    end else begin
      en_p0 <= En_Async;
      en_p1 <= en_p0;
    end
  end

  assign En_Sync = en_p1;

endmodule

// File: rtl/clock_100_gen.sv
// Divides Clk to a 50%-duty Clk_Out with edge strobes and a rise counter.
// Define CLOCK_100_GEN_EN_SYNC_EN to pass En through a two-flop synchronizer.
module clock_100_gen
  import clock_100_pkg::*;
#(
  parameter int HALF_PERIOD = HALF_PERIOD_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             En,
  output logic             Clk_Out,
  output logic             Rise_Pulse,
  output logic             Fall_Pulse,
  output logic [CNT_W-1:0] Cycle_Count
);

  localparam int              HC_W    = hc_width(HALF_PERIOD);
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(HALF_PERIOD - 1);

  logic            en_p0;
  logic [HC_W-1:0] hc;
  logic            terminal;

`ifdef CLOCK_100_GEN_EN_SYNC_EN
  clock_100_en_sync u_en_sync (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .En_Async (En),
    .En_Sync  (en_p0)
  );
`else
  assign en_p0 = En;
`endif

  assign terminal = (hc == HC_LAST);

  // Stage 0 -> outputs: pulses are registered with the new Clk_Out level
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hc          <= '0;
      Clk_Out     <= 1'b0;
      Rise_Pulse  <= 1'b0;
      Fall_Pulse  <= 1'b0;
      Cycle_Count <= '0;
    end else begin
      Rise_Pulse <= 1'b0;
      Fall_Pulse <= 1'b0;
      if (en_p0) begin
        if (terminal) begin
          hc         <= '0;
          Clk_Out    <= ~Clk_Out;
          Rise_Pulse <= ~Clk_Out;
          Fall_Pulse <= Clk_Out;
          if (!Clk_Out) begin
            Cycle_Count <= Cycle_Count + CNT_W'(1);
          end
        end else begin
          hc <= hc + HC_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_clock_100_gen.sv
// Directed bench for clock_100_gen: table of enable phases plus reset, steady-state and wrap sequences.
`timescale 1ns/10ps
module tb_clock_100_gen;

  localparam int HP = 50;
`ifdef CLOCK_100_GEN_EN_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  typedef struct {
    logic en;
    int   cyc;
    logic clk;
    logic rise;
    logic fall;
    int   cnt;
  } vec_t;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        En = 1'b0;
  logic        clk_out, rise, fall;
  logic [15:0] cnt;
  logic        s_clk_out, s_rise, s_fall;
  logic [3:0]  s_cnt;

  int checks = 0;
  int failures = 0;
  int overlap = 0;
  int pulse_seen = 0;

  vec_t tbl[14];

  clock_100_gen #(.HALF_PERIOD(HP), .CNT_W(16)) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .En          (En),
    .Clk_Out     (clk_out),
    .Rise_Pulse  (rise),
    .Fall_Pulse  (fall),
    .Cycle_Count (cnt)
  );

  clock_100_gen #(.HALF_PERIOD(1), .CNT_W(4)) dut_small (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .En          (En),
    .Clk_Out     (s_clk_out),
    .Rise_Pulse  (s_rise),
    .Fall_Pulse  (s_fall),
    .Cycle_Count (s_cnt)
  );

  always #0.5 Clk = ~Clk;

  always @(negedge Clk) begin
    if ((rise && fall) || (s_rise && s_fall)) overlap++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      #0.2;
      if (rise || fall) pulse_seen++;
    end
  endtask

  initial begin
    int   since, rises, falls, badlen;
    logic last_rise;
    logic prev_clk;

    tbl[0]  = '{1'b1, 49, 1'b0, 1'b0, 1'b0, 0};
    tbl[1]  = '{1'b1,  1, 1'b1, 1'b1, 1'b0, 1};
    tbl[2]  = '{1'b1,  1, 1'b1, 1'b0, 1'b0, 1};
    tbl[3]  = '{1'b1, 48, 1'b1, 1'b0, 1'b0, 1};
    tbl[4]  = '{1'b1,  1, 1'b0, 1'b0, 1'b1, 1};
    tbl[5]  = '{1'b1, 50, 1'b1, 1'b1, 1'b0, 2};
    tbl[6]  = '{1'b1, 20, 1'b1, 1'b0, 1'b0, 2};
    tbl[7]  = '{1'b0, 37, 1'b1, 1'b0, 1'b0, 2};
    tbl[8]  = '{1'b1, 29, 1'b1, 1'b0, 1'b0, 2};
    tbl[9]  = '{1'b1,  1, 1'b0, 1'b0, 1'b1, 2};
    tbl[10] = '{1'b0,  1, 1'b0, 1'b0, 1'b0, 2};
    tbl[11] = '{1'b1, 49, 1'b0, 1'b0, 1'b0, 2};
    tbl[12] = '{1'b0,  1, 1'b0, 1'b0, 1'b0, 2};
    tbl[13] = '{1'b1,  1, 1'b1, 1'b1, 1'b0, 3};

    // Reset held with clocks running
    Reset_n = 1'b0;
    En = 1'b1;
    step(5);
    chk("rst.clk", clk_out, 1'b0);
    chk("rst.rise", rise, 1'b0);
    chk("rst.fall", fall, 1'b0);
    chk("rst.cnt", cnt, 0);
    chk("rst.small_clk", s_clk_out, 1'b0);
    chk("rst.small_cnt", s_cnt, 0);
    Reset_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      En = tbl[i].en;
      pulse_seen = 0;
      prev_clk = clk_out;
      step(tbl[i].cyc + ((i == 0) ? SL : 0));
      chk($sformatf("vec%0d.clk", i), clk_out, tbl[i].clk);
      chk($sformatf("vec%0d.rise", i), rise, tbl[i].rise);
      chk($sformatf("vec%0d.fall", i), fall, tbl[i].fall);
      chk($sformatf("vec%0d.cnt", i), cnt, tbl[i].cnt);
      if (!tbl[i].en) begin
        chk($sformatf("vec%0d.frozen_clk", i), clk_out, prev_clk);
        chk($sformatf("vec%0d.frozen_pulses", i), pulse_seen, 0);
      end
    end

    // Steady state: 10000 cycles from a fresh rise
    En = 1'b1;
    since = 0; rises = 0; falls = 0; badlen = 0; last_rise = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      step(1);
      since++;
      if (rise || fall) begin
        if (since != HP) badlen++;
        if (rise && (clk_out !== 1'b1 || last_rise)) badlen++;
        if (fall && (clk_out !== 1'b0 || !last_rise)) badlen++;
        if (rise) begin rises++; last_rise = 1'b1; end
        if (fall) begin falls++; last_rise = 1'b0; end
        since = 0;
      end
    end
    chk("steady.rises", rises, 100);
    chk("steady.falls", falls, 100);
    chk("steady.spacing", badlen, 0);
    chk("steady.cnt", cnt, 103);

    // Asynchronous reset in the middle of the high phase
    step(25);
    chk("async.pre_clk", clk_out, 1'b1);
    #0.1;
    Reset_n = 1'b0;
    #0.1;
    chk("async.clk", clk_out, 1'b0);
    chk("async.cnt", cnt, 0);
    chk("async.small_cnt", s_cnt, 0);
    step(3);
    chk("async.hold_clk", clk_out, 1'b0);
    chk("async.hold_rise", rise, 1'b0);
    Reset_n = 1'b1;

    // HALF_PERIOD=1 instance: toggles every edge, 4-bit count wraps on the 16th rise
    step(1 + SL);
    chk("small.e1_clk", s_clk_out, 1'b1);
    chk("small.e1_rise", s_rise, 1'b1);
    chk("small.e1_cnt", s_cnt, 1);
    step(1);
    chk("small.e2_clk", s_clk_out, 1'b0);
    chk("small.e2_fall", s_fall, 1'b1);
    chk("small.e2_cnt", s_cnt, 1);
    step(27);
    chk("small.e29_cnt", s_cnt, 15);
    chk("small.e29_clk", s_clk_out, 1'b1);
    step(1);
    chk("small.e30_clk", s_clk_out, 1'b0);
    step(1);
    chk("small.e31_cnt", s_cnt, 0);
    chk("small.e31_rise", s_rise, 1'b1);
    chk("small.e31_clk", s_clk_out, 1'b1);

    // Main instance restarts its half period from zero after reset
    step(18);
    chk("restart.e49_clk", clk_out, 1'b0);
    chk("restart.e49_cnt", cnt, 0);
    step(1);
    chk("restart.e50_clk", clk_out, 1'b1);
    chk("restart.e50_rise", rise, 1'b1);
    chk("restart.e50_cnt", cnt, 1);

    chk("never_both_pulses", overlap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
